// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencing: arbitrates trap/EX/ID redirects against hazards and
// instruction-memory back-pressure, and drives PC control plus pipeline flushes.
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trap_valid,
  input  logic [31:0] trap_target,
  input  logic        ex_redirect_valid,
  input  logic [31:0] ex_redirect_target,
  input  logic        id_jump_valid,
  input  logic [31:0] id_jump_target,
  input  logic        hazard_stall,
  input  logic        imem_ready,
  output logic        pc_stall,
  output logic        pc_jump_enable,
  output logic [31:0] pc_jump_address,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic [15:0] redirect_count
);

  typedef enum logic {RUN, HOLD} state_t;
  // Encoding order doubles as priority: a larger value wins.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ID   = 2'd1,
    SRC_EX   = 2'd2,
    SRC_TRAP = 2'd3
  } src_t;

  state_t      state;
  src_t        pending_src;
  logic        pending_valid;
  logic [31:0] pending_target;

  src_t        sel_src;
  logic [31:0] sel_target;
  logic        sel_valid;
  logic        take_new;
  logic [31:0] eff_target;
  logic [2:0]  flush_vec;

  function automatic logic [2:0] flush_of(input src_t s);
    case (s)
      SRC_TRAP: flush_of = 3'b111;
      SRC_EX:   flush_of = 3'b110;
      SRC_ID:   flush_of = 3'b100;
      default:  flush_of = 3'b000;
    endcase
  endfunction

  always_comb begin
    sel_src    = SRC_NONE;
    sel_target = '0;
    if (trap_valid) begin
      sel_src    = SRC_TRAP;
      sel_target = trap_target;
    end else if (ex_redirect_valid) begin
      sel_src    = SRC_EX;
      sel_target = ex_redirect_target;
    end else if (id_jump_valid && !hazard_stall) begin
      sel_src    = SRC_ID;
      sel_target = id_jump_target;
    end
  end

  assign sel_valid  = (sel_src != SRC_NONE);
  // In HOLD an incoming request only displaces the pending one at equal or higher priority.
  assign take_new   = sel_valid &&
                      ((state == RUN) || !pending_valid || (sel_src >= pending_src));
  assign eff_target = take_new ? sel_target : pending_target;

  always_comb begin
    pc_stall        = 1'b0;
    pc_jump_enable  = 1'b0;
    pc_jump_address = eff_target;
    flush_vec       = 3'b000;
    if (reset) begin
      pc_jump_enable  = 1'b1;
      pc_jump_address = RESET_VECTOR;
      flush_vec       = 3'b111;
    end else begin
      case (state)
        RUN: begin
          if (sel_valid) begin
            flush_vec = flush_of(sel_src);
            if (imem_ready) pc_jump_enable = 1'b1;
            else            pc_stall       = 1'b1;
          end else begin
            pc_stall = hazard_stall | ~imem_ready;
          end
        end
        HOLD: begin
          if (take_new) flush_vec = flush_of(sel_src);
          if (imem_ready) pc_jump_enable = 1'b1;
          else            pc_stall       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign flush_if = flush_vec[2];
  assign flush_id = flush_vec[1];
  assign flush_ex = flush_vec[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      pending_valid  <= 1'b0;
      pending_target <= '0;
      pending_src    <= SRC_NONE;
      redirect_count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (sel_valid) begin
            if (imem_ready) begin
              redirect_count <= redirect_count + 16'd1;
            end else begin
              pending_target <= sel_target;
              pending_src    <= sel_src;
              pending_valid  <= 1'b1;
              state          <= HOLD;
            end
          end
        end
        HOLD: begin
          if (take_new) begin
            pending_target <= sel_target;
            pending_src    <= sel_src;
          end
          if (imem_ready) begin
            redirect_count <= redirect_count + 16'd1;
            pending_valid  <= 1'b0;
            pending_src    <= SRC_NONE;
            state          <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl with a scoreboard of expected outputs
// and a small PC register model driven by the controller's outputs.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        trap_valid, ex_redirect_valid, id_jump_valid;
  logic [31:0] trap_target, ex_redirect_target, id_jump_target;
  logic        hazard_stall, imem_ready;
  logic        pc_stall, pc_jump_enable;
  logic [31:0] pc_jump_address;
  logic        flush_if, flush_id, flush_ex;
  logic [15:0] redirect_count;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  typedef struct packed {
    logic        stall;
    logic        jen;
    logic [31:0] addr;
    logic [2:0]  flush;
    logic [15:0] count;
  } exp_t;

  exp_t sb[$];
  logic [31:0] pc;

  fetch_redirect_ctrl #(.RESET_VECTOR(32'h0000_0200)) dut (
    .clk(clk), .reset(reset),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .ex_redirect_valid(ex_redirect_valid), .ex_redirect_target(ex_redirect_target),
    .id_jump_valid(id_jump_valid), .id_jump_target(id_jump_target),
    .hazard_stall(hazard_stall), .imem_ready(imem_ready),
    .pc_stall(pc_stall), .pc_jump_enable(pc_jump_enable), .pc_jump_address(pc_jump_address),
    .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
    .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  // PC register as the fetch stage would implement it.
  always @(posedge clk) begin
    if (pc_jump_enable)  pc <= pc_jump_address;
    else if (!pc_stall)  pc <= pc + 32'd4;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic stall, input logic jen, input logic [31:0] addr,
                            input logic [2:0] flush, input logic [15:0] count);
    exp_t e;
    e.stall = stall; e.jen = jen; e.addr = addr; e.flush = flush; e.count = count;
    sb.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    #2;
    e = sb.pop_front();
    checks++;
    assert (pc_stall === e.stall) else begin
      failures++; $error("FAIL %s.stall observed=%b expected=%b", tag, pc_stall, e.stall);
    end
    checks++;
    assert (pc_jump_enable === e.jen) else begin
      failures++; $error("FAIL %s.jen observed=%b expected=%b", tag, pc_jump_enable, e.jen);
    end
    if (e.jen) begin
      checks++;
      assert (pc_jump_address === e.addr) else begin
        failures++; $error("FAIL %s.addr observed=%h expected=%h", tag, pc_jump_address, e.addr);
      end
    end
    checks++;
    assert ({flush_if, flush_id, flush_ex} === e.flush) else begin
      failures++; $error("FAIL %s.flush observed=%b expected=%b", tag, {flush_if, flush_id, flush_ex}, e.flush);
    end
    checks++;
    assert (redirect_count === e.count) else begin
      failures++; $error("FAIL %s.count observed=%h expected=%h", tag, redirect_count, e.count);
    end
    checks++;
    assert (!(pc_jump_enable && pc_stall)) else begin
      failures++; $error("FAIL %s.jen_stall observed=%b expected=0", tag, pc_jump_enable & pc_stall);
    end
  endtask

  task automatic check_pc(input string tag, input logic [31:0] exp_pc);
    checks++;
    assert (pc === exp_pc) else begin
      failures++; $error("FAIL %s.pc observed=%h expected=%h", tag, pc, exp_pc);
    end
  endtask

  task automatic idle();
    trap_valid = 0; ex_redirect_valid = 0; id_jump_valid = 0; hazard_stall = 0;
  endtask

  initial begin
    reset = 1; idle(); imem_ready = 1;
    trap_target = 32'h100; ex_redirect_target = 32'h40; id_jump_target = 32'h80;

    // Reset held for two cycles
    cyc(); expect_out(0, 1, 32'h200, 3'b111, 16'h0); check("reset0");
    cyc(); expect_out(0, 1, 32'h200, 3'b111, 16'h0); check("reset1");
    cyc(); reset = 0;
    expect_out(0, 0, 32'h0, 3'b000, 16'h0); check("run_idle");
    check_pc("pc_seq0", 32'h200);
    cyc(); check_pc("pc_seq1", 32'h204);
    cyc(); check_pc("pc_seq2", 32'h208);

    // EX redirect, memory ready
    ex_redirect_valid = 1;
    expect_out(0, 1, 32'h40, 3'b110, 16'h0); check("ex_issue");
    cyc(); ex_redirect_valid = 0;
    check_pc("ex_pc", 32'h40);
    expect_out(0, 0, 32'h0, 3'b000, 16'h1); check("ex_after");

    // ID jump masked by hazard, then re-presented
    id_jump_valid = 1; hazard_stall = 1;
    expect_out(1, 0, 32'h0, 3'b000, 16'h1); check("id_hazard");
    cyc(); hazard_stall = 0;
    check_pc("hazard_pc", 32'h40);
    expect_out(0, 1, 32'h80, 3'b100, 16'h1); check("id_issue");
    cyc(); id_jump_valid = 0;
    check_pc("id_pc", 32'h80);

    // ID jump latched, overwritten by trap while not ready
    id_jump_valid = 1; imem_ready = 0;
    expect_out(1, 0, 32'h0, 3'b100, 16'h2); check("id_latch");
    cyc(); id_jump_valid = 0; trap_valid = 1;
    expect_out(1, 0, 32'h0, 3'b111, 16'h2); check("trap_overwrite");
    cyc(); trap_valid = 0;
    expect_out(1, 0, 32'h0, 3'b000, 16'h2); check("hold_wait");
    cyc(); imem_ready = 1;
    expect_out(0, 1, 32'h100, 3'b000, 16'h2); check("hold_issue");
    cyc();
    check_pc("hold_pc", 32'h100);
    expect_out(0, 0, 32'h0, 3'b000, 16'h3); check("hold_done");

    // Simultaneous requests: trap wins
    trap_valid = 1; ex_redirect_valid = 1; id_jump_valid = 1;
    expect_out(0, 1, 32'h100, 3'b111, 16'h3); check("all_three");
    cyc(); idle();
    expect_out(0, 0, 32'h0, 3'b000, 16'h4); check("all_three_after");

    // Lower-priority request in HOLD is dropped
    ex_redirect_valid = 1; imem_ready = 0;
    expect_out(1, 0, 32'h0, 3'b110, 16'h4); check("ex_latch");
    cyc(); ex_redirect_valid = 0; id_jump_valid = 1; imem_ready = 1;
    expect_out(0, 1, 32'h40, 3'b000, 16'h4); check("id_dropped");
    cyc(); idle();
    check_pc("drop_pc", 32'h40);
    expect_out(0, 0, 32'h0, 3'b000, 16'h5); check("drop_after");

    // Reset while holding discards the pending redirect
    ex_redirect_valid = 1; imem_ready = 0;
    expect_out(1, 0, 32'h0, 3'b110, 16'h5); check("pre_reset_latch");
    cyc(); ex_redirect_valid = 0; reset = 1;
    expect_out(0, 1, 32'h200, 3'b111, 16'h5); check("reset_in_hold");
    cyc(); reset = 0; imem_ready = 1;
    check_pc("reset_hold_pc", 32'h200);
    expect_out(0, 0, 32'h0, 3'b000, 16'h0); check("pending_cleared");
    cyc();
    check_pc("reset_hold_pc2", 32'h204);

    // Counter wrap
    ex_redirect_valid = 1;
    for (int i = 0; i < 65535; i++) cyc();
    ex_redirect_valid = 0;
    expect_out(0, 0, 32'h0, 3'b000, 16'hFFFF); check("count_ffff");
    ex_redirect_valid = 1;
    cyc(); ex_redirect_valid = 0;
    expect_out(0, 0, 32'h0, 3'b000, 16'h0000); check("count_wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
